// File: rtl/spi3w_master_if.sv
// Control and pin bundle for the three-wire SPI master: start/busy/done handshake
// from the register wrapper plus the SCLK/CSN/SDIO buffer-side pins.
interface spi3w_master_if;
  logic        start;
  logic        rw;
  logic [6:0]  addr;
  logic [1:0]  nbytes;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        sclk;
  logic        csn;
  logic        sdio_i;
  logic        sdio_t;
  logic        sdio_o;

  modport master (
    input  start, rw, addr, nbytes, wdata, sdio_o,
    output busy, done, rdata, sclk, csn, sdio_i, sdio_t
  );

  modport slave (
    output start, rw, addr, nbytes, wdata, sdio_o,
    input  busy, done, rdata, sclk, csn, sdio_i, sdio_t
  );
endinterface

// File: rtl/spi3w_master.sv
// Three-wire SPI master (mode 3, shared SDIO): one command byte then 1-4 data
// bytes, read or write, with a start/busy/done handshake.
module spi3w_master #(
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           resetn,
  spi3w_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, DONE} state_t;
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [5:0]  bit_idx;
  logic [5:0]  last_idx;
  logic [5:0]  nxt_idx;
  logic        rw_q;
  logic        sclk_q;
  logic        csn_q;
  logic        sdio_i_q;
  logic        sdio_t_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic [31:0] rx_sr;
  logic [31:0] wdata_al;
  logic [39:0] tx_sr;
  logic        accept;
  logic        tick;
  logic        bit_start;
  logic        bit_rise;
  logic        nxt_rd;

  // busy is low only in IDLE and DONE, which is what makes back-to-back starts work
  always_comb begin
    accept    = bus.start && !busy_q;
    tick      = (cnt == 8'd0);
    bit_start = tick && ((state == SETUP) ||
                         (state == SHIFT && sclk_q && bit_idx != last_idx));
    bit_rise  = tick && (state == SHIFT) && !sclk_q;
    nxt_idx   = (state == SETUP) ? 6'd0 : bit_idx + 6'd1;
    nxt_rd    = rw_q && (nxt_idx >= 6'd8);
    wdata_al  = bus.wdata << {~bus.nbytes, 3'b000};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      last_idx <= '0;
      rw_q     <= 1'b0;
      sclk_q   <= 1'b1;
      csn_q    <= 1'b1;
      sdio_i_q <= 1'b0;
      sdio_t_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state    <= SETUP;
        cnt      <= RELOAD;
        rw_q     <= bus.rw;
        last_idx <= {1'b0, bus.nbytes, 3'b000} + 6'd15;
        sclk_q   <= 1'b1;
        csn_q    <= 1'b0;
        sdio_i_q <= 1'b0;
        sdio_t_q <= 1'b0;
        busy_q   <= 1'b1;
      end else begin
        if (busy_q) cnt <= tick ? RELOAD : cnt - 8'd1;
        // Falling SCLK launches the next bit; read data bits release the line
        if (bit_start) begin
          sclk_q   <= 1'b0;
          bit_idx  <= nxt_idx;
          sdio_i_q <= nxt_rd ? 1'b0 : tx_sr[39];
          sdio_t_q <= nxt_rd;
        end
        if (bit_rise) sclk_q <= 1'b1;
        case (state)
          SETUP: if (tick) state <= SHIFT;
          SHIFT: if (tick && sclk_q && bit_idx == last_idx) state <= HOLD;
          HOLD: if (tick) begin
            state    <= GAP;
            csn_q    <= 1'b1;
            sdio_t_q <= 1'b1;
            sdio_i_q <= 1'b0;
          end
          GAP: if (tick) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            if (rw_q) rdata_q <= rx_sr;
          end
          DONE:    state <= IDLE;
          default: ;
        endcase
      end
    end
  end

  // Datapath shift registers carry no reset; both are reloaded on every accept
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= {bus.rw, bus.addr, wdata_al};
      rx_sr <= '0;
    end else begin
      if (bit_start) tx_sr <= {tx_sr[38:0], 1'b0};
      if (bit_rise && rw_q && bit_idx >= 6'd8) rx_sr <= {rx_sr[30:0], bus.sdio_o};
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
  assign bus.sclk   = sclk_q;
  assign bus.csn    = csn_q;
  assign bus.sdio_i = sdio_i_q;
  assign bus.sdio_t = sdio_t_q;

endmodule

// File: doc/spi3w_master.md
Name: spi3w_master

Overview:
- Three-wire (shared SDIO) SPI master for the gyro tester; transfers one read or write of 1-4 data bytes to the device under test.
- Sits directly upstream of the SDIO tristate I/O buffer. sdio_i drives the buffer I input, sdio_t drives its T input (1 = hi-Z), and sdio_o takes its O output.
- Controlled by the register/AXI wrapper through a start/busy/done interface.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 1 to 255.

Ports:
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request transfer; accepted only when busy=0
- rw  in  1  1 = read, 0 = write; latched on accept
- addr  in  7  register address; latched on accept
- nbytes  in  2  data byte count minus 1 (0 → 1 byte … 3 → 4 bytes); latched on accept
- wdata  in  32  write data, right-justified, sent MSB-first; latched on accept
- busy  out  1  high from the cycle after accept through the done cycle exclusive
- done  out  1  one-cycle pulse at transfer end
- rdata  out  32  read data, right-justified, zero-extended; updated only in the done cycle of a read
- sclk  out  1  SPI clock, idle high (mode 3)
- csn  out  1  chip select, active low
- sdio_i  out  1  serial data to I/O buffer I
- sdio_t  out  1  tristate enable to I/O buffer T; 1 = release line
- sdio_o  in  1  serial data from I/O buffer O

Behaviour:
- Reset (asynchronous, immediate on resetn low, including mid-transfer): csn=1, sclk=1, sdio_t=1, sdio_i=0, busy=0, done=0, rdata=0, FSM=IDLE. No partial frame resumes after reset.
- Frame: 8 command bits, MSB first. The first bit is rw; the next 7 bits are addr[6:0]. Then 8*(nbytes+1) data bits.
- Time unit H = CLK_DIV clk cycles. A half-period counter reloads on every phase change.
- FSM states and durations:
  - IDLE: csn=1, sclk=1, sdio_t=1. A start with busy=0 latches the inputs and moves to SETUP at the next edge. csn=0 and busy=1 in that same cycle.
  - SETUP: one H; sclk=1.
  - SHIFT: two H per bit.
    - sclk falls at the start of each bit; sdio_i updates to the next bit in that same cycle.
    - sclk rises after H. sdio_o is sampled on the clk edge where sclk returns to 1.
  - HOLD: one H after the last rising edge; sclk=1, csn=0.
  - GAP: one H with csn=1 and sdio_t=1. Then DONE.
  - DONE: one cycle; done=1, busy=0. Back to IDLE. A start in the DONE cycle is accepted (back-to-back transfers).
- Bus direction:
  - sdio_t=0 from SETUP entry through the last command bit.
  - Write: sdio_t stays 0 through HOLD.
  - Read: sdio_t=1 from the falling sclk edge of the first data bit onward; sdio_i=0 while released.
  - sdio_o is only sampled into the shift register during read data bits. Command-phase samples are discarded.
- Transfer length in clk cycles, from the first busy cycle through the done cycle: CLK_DIV*(3 + 2*(8 + 8*(nbytes+1))) + 1.
  - Example: CLK_DIV=2, 1 byte → 71.
- rdata:
  - Received bits shift in LSB-side. The first received bit lands at bit 8*(nbytes+1)-1 and upper bits are 0.
  - rdata holds its value through writes and subsequent idle time.
- Ignored inputs: start while busy=1 is ignored, with no effect on latched fields. Changes to rw/addr/nbytes/wdata after accept have no effect.
- sclk, csn, sdio_i and sdio_t are driven directly from flops (glitch-free).

Test Plan:
- Write, CLK_DIV=2, rw=0, addr=0x2A, nbytes=0, wdata=0xA5 → on SCLK rising edges the line carries 0x2A then 0xA5 (command byte = {rw=0, addr}). sdio_t=0 throughout csn low. done pulses exactly 71 cycles after the first busy cycle. rdata is unchanged.
- Read 2 bytes, slave model returns 0xC3,0x5E, addr=0x0F → command byte 0x8F. sdio_t rises at the falling edge of data bit 0. rdata=0x0000C35E at done.
- Read 4 bytes with CLK_DIV=1, slave returns 0xDEADBEEF → rdata=0xDEADBEEF. sclk period = 2 clk cycles. Issue start in the DONE cycle → the second transfer begins with no idle cycle.
- Start pulsed mid-transfer with different addr/wdata → ignored; the frame on the wire matches the first request and only one done pulse occurs.
- Drop resetn during data bit 5 of a write → csn=1, sclk=1, sdio_t=1, busy=0 immediately without waiting for clk. After release, a new 1-byte write completes normally.
- Timing check, CLK_DIV=4, 3-byte write → sclk low/high widths exactly 4 cycles each. Total transfer length 4*(3+64)+1 = 269 cycles. csn high for ≥4 cycles before the next frame.
